// File: rtl/fb_sram_arbiter.sv
// Frame-buffer SRAM arbiter: three requesters, urgent-qualified scan-out priority,
// round-robin otherwise. Define FB_ARB_STATS_EN for per-requester grant counters.
module fb_sram_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 4,
  parameter int MAX_BURST = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [2:0]          req,
  input  logic                urgent,
  input  logic [3*LEN_W-1:0]  burst_len,
  input  logic [3*ADDR_W-1:0] addr,
  input  logic [3*DATA_W-1:0] wdata,
  input  logic [2:0]          we,
  output logic [2:0]          gnt,
  output logic [2:0]          beat_ack,
  output logic [DATA_W-1:0]   rdata,
  output logic [2:0]          rvalid,
  output logic                busy,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata
`ifdef FB_ARB_STATS_EN
  ,
  output logic [3*16-1:0]     grant_cnt,
  input  logic                stats_clr
`endif
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t                   state, state_d;
  logic [CNT_W-1:0]         beat_cnt, cnt_d;
  logic [1:0]               gsel, gsel_d;
  logic [1:0]               rr_ptr, rr_d;
  logic [1:0]               win;
  logic                     win_urgent;
  logic [2:0]               arb_idx;
  logic [2:0]               gsel_oh;

  // Pad to four entries so a 2-bit select never leaves the array.
  logic [3:0][LEN_W-1:0]    len_f;
  logic [3:0][ADDR_W-1:0]   addr_f;
  logic [3:0][DATA_W-1:0]   wdata_f;
  logic [3:0]               req_f, we_f;

  assign len_f   = {LEN_W'(0), burst_len};
  assign addr_f  = {ADDR_W'(0), addr};
  assign wdata_f = {DATA_W'(0), wdata};
  assign req_f   = {1'b0, req};
  assign we_f    = {1'b0, we};
  assign gsel_oh = 3'b001 << gsel;
  assign busy    = (state != IDLE);

  function automatic logic [CNT_W-1:0] eff_len(input logic [LEN_W-1:0] f);
    int v;
    v = 32'(f);
    if (v == 0) v = 1;
    else if (v > MAX_BURST) v = MAX_BURST;
    return CNT_W'(v);
  endfunction

  // Urgent scan-out preempts the rotation without advancing it.
  always_comb begin
    win        = 2'd0;
    win_urgent = 1'b0;
    arb_idx    = 3'd0;
    if (req[2] && urgent) begin
      win        = 2'd2;
      win_urgent = 1'b1;
    end else begin
      for (int k = 2; k >= 0; k--) begin
        arb_idx = {1'b0, rr_ptr} + 3'(k);
        if (arb_idx >= 3'd3) arb_idx = arb_idx - 3'd3;
        if (req_f[arb_idx[1:0]]) win = arb_idx[1:0];
      end
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = beat_cnt;
    gsel_d    = gsel;
    rr_d      = rr_ptr;
    gnt       = '0;
    beat_ack  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          state_d = BURST;
          gsel_d  = win;
          cnt_d   = eff_len(len_f[win]);
          if (!win_urgent) rr_d = (win == 2'd2) ? 2'd0 : win + 2'd1;
        end
      end
      BURST: begin
        gnt = gsel_oh;
        if (req_f[gsel]) begin
          beat_ack  = gsel_oh;
          mem_addr  = addr_f[gsel];
          mem_wdata = wdata_f[gsel];
          mem_we    = we_f[gsel];
          mem_re    = ~we_f[gsel];
          cnt_d     = beat_cnt - CNT_W'(1);
          if (beat_cnt == CNT_W'(1)) state_d = GAP;
        end else begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state    <= IDLE;
      beat_cnt <= '0;
      gsel     <= 2'd0;
      rr_ptr   <= 2'd0;
    end else begin
      state    <= state_d;
      beat_cnt <= cnt_d;
      gsel     <= gsel_d;
      rr_ptr   <= rr_d;
    end
  end

  // Read data lands one cycle after the beat, even when that cycle is GAP.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= mem_re ? gsel_oh : 3'b000;
      if (mem_re) rdata <= mem_rdata;
    end
  end

`ifdef FB_ARB_STATS_EN
  logic grant_now;
  assign grant_now = (state == IDLE) && (|req);

  for (genvar i = 0; i < 3; i++) begin : g_stats
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (!n_rst || stats_clr) cnt <= '0;
      else if (grant_now && win == 2'(i) && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
    assign grant_cnt[i*16 +: 16] = cnt;
  end
`endif

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Directed bench for fb_sram_arbiter: beat/read-return scoreboard plus per-cycle grant checks.
module tb_fb_sram_arbiter;

  typedef struct packed { logic [1:0] idx; logic [15:0] addr; logic we; } beat_t;
  typedef struct packed { logic [1:0] idx; logic [31:0] data; } rd_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [2:0]  req = '0, we = '0;
  logic        urgent = 1'b0;
  logic [3:0]  len [3];
  logic [15:0] a [3];
  logic [11:0] burst_len;
  logic [47:0] addr_v;
  logic [95:0] wdata_v;
  logic [2:0]  gnt, beat_ack, rvalid;
  logic [31:0] rdata, mem_wdata, mem_rdata;
  logic        busy, mem_we, mem_re;
  logic [15:0] mem_addr;
`ifdef FB_ARB_STATS_EN
  logic [47:0] grant_cnt;
  logic        stats_clr = 1'b0;
`endif

  beat_t beat_q[$];
  rd_t   rd_q[$];
  int    n_tests = 0, n_fail = 0, acks;
  logic [2:0]  s_gnt, s_ack, s_rvalid;
  logic        s_busy;
  logic [27:0] s_ctl;
  logic [63:0] s_dat;

  function automatic logic [31:0] wd(input logic [1:0] i, input logic [15:0] ad);
    return {14'd0, i, ad};
  endfunction

  assign burst_len = {len[2], len[1], len[0]};
  assign addr_v    = {a[2], a[1], a[0]};
  assign wdata_v   = {wd(2'd2, a[2]), wd(2'd1, a[1]), wd(2'd0, a[0])};
  assign mem_rdata = 32'hA000 + {16'd0, mem_addr};

  always #5 clk = ~clk;

  fb_sram_arbiter #(.ADDR_W(16), .DATA_W(32), .LEN_W(4), .MAX_BURST(8)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .urgent(urgent), .burst_len(burst_len),
    .addr(addr_v), .wdata(wdata_v), .we(we), .gnt(gnt), .beat_ack(beat_ack),
    .rdata(rdata), .rvalid(rvalid), .busy(busy), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .stats_clr(stats_clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_beats(input logic [1:0] idx, input logic [15:0] start, input int n,
                            input logic w);
    for (int k = 0; k < n; k++) beat_q.push_back('{idx, start + 16'(k), w});
  endtask

  // One clock: sample/score at negedge, then advance acked requesters after the edge.
  task automatic step();
    beat_t b;
    rd_t   r;
    @(negedge clk);
    s_gnt = gnt; s_ack = beat_ack; s_rvalid = rvalid; s_busy = busy;
    s_ctl = {gnt, beat_ack, rvalid, busy, mem_we, mem_re, mem_addr};
    s_dat = {mem_wdata, rdata};
    if (rvalid != 3'b000) begin
      if (rd_q.size() == 0) chk("rvalid_unexpected", rvalid, 3'b000);
      else begin
        r = rd_q.pop_front();
        chk("rvalid", rvalid, 3'b001 << r.idx);
        chk("rdata", rdata, r.data);
      end
    end
    if (beat_ack != 3'b000) begin
      if (beat_q.size() == 0) chk("beat_unexpected", beat_ack, 3'b000);
      else begin
        b = beat_q.pop_front();
        chk("beat_ack", beat_ack, 3'b001 << b.idx);
        chk("mem_addr", mem_addr, b.addr);
        chk("mem_we_re", {mem_we, mem_re}, {b.we, ~b.we});
        if (b.we) chk("mem_wdata", mem_wdata, wd(b.idx, b.addr));
        else rd_q.push_back('{b.idx, 32'hA000 + {16'd0, b.addr}});
      end
    end else begin
      chk("no_access", {mem_we, mem_re}, 2'b00);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) if (s_ack[i]) a[i] = a[i] + 16'd1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] exp_g [16] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0,
                               3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd2, 3'd2, 3'd0};
    for (int i = 0; i < 3; i++) begin len[i] = 4'd0; a[i] = 16'd0; end
    repeat (2) @(posedge clk);
    #1;
    step();
    chk("reset_ctl", s_ctl, 28'd0);
    chk("reset_dat", s_dat, 64'd0);

    // Single 3-beat write burst from the draw engine
    n_rst = 1'b1; req = 3'b001; len[0] = 4'd3; we = 3'b001; a[0] = 16'h0100;
    push_beats(2'd0, 16'h0100, 3, 1'b1);
    step(); chk("s1_idle_gnt", s_gnt, 3'b000);
    for (int k = 0; k < 3; k++) begin step(); chk("s1_gnt", s_gnt, 3'b001); end
    req = 3'b000;
    step(); chk("s1_gap", {s_gnt, s_busy}, {3'b000, 1'b1});
    step(); chk("s1_idle_busy", s_busy, 1'b0);

    // Round-robin between 0 and 1 from rr_ptr=0
    n_rst = 1'b0; step();
    n_rst = 1'b1; req = 3'b011; len[0] = 4'd2; len[1] = 4'd2; we = 3'b011;
    a[0] = 16'h0300; a[1] = 16'h0400;
    push_beats(2'd0, 16'h0300, 2, 1'b1); push_beats(2'd1, 16'h0400, 2, 1'b1);
    push_beats(2'd0, 16'h0302, 2, 1'b1); push_beats(2'd1, 16'h0402, 2, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("s2_gnt", s_gnt, exp_g[k]);
      if (k == 14) req = 3'b000;
    end
    chk("s2_queue_empty", beat_q.size(), 0);

    // One grant to 0 so rr_ptr=1, then urgent scan-out read burst, then requester 1
    req = 3'b001; len[0] = 4'd1; we = 3'b001; a[0] = 16'h0600;
    push_beats(2'd0, 16'h0600, 1, 1'b1);
    step(); step(); req = 3'b000; step(); step();
    req = 3'b111; urgent = 1'b1; len[2] = 4'd4; len[1] = 4'd1; we = 3'b011;
    a[2] = 16'h0200; a[1] = 16'h0500;
    push_beats(2'd2, 16'h0200, 4, 1'b0); push_beats(2'd1, 16'h0500, 1, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      chk("s3_gnt", s_gnt, (k >= 1 && k <= 4) ? 3'b100 : (k == 7) ? 3'b010 : 3'b000);
      chk("s3_rvalid", s_rvalid, (k >= 2 && k <= 5) ? 3'b100 : 3'b000);
      if (k == 1) urgent = 1'b0;
      if (k == 7) req = 3'b000;
    end
    chk("s3_rd_empty", rd_q.size(), 0);

    // Length 15 clamped, but released after 5 beats
    req = 3'b001; len[0] = 4'd15; we = 3'b001; a[0] = 16'h0800; acks = 0;
    push_beats(2'd0, 16'h0800, 5, 1'b1);
    for (int k = 0; k < 9; k++) begin
      step();
      acks += int'(s_ack != 3'b000);
      if (k == 5) req = 3'b000;
      if (k == 6) chk("s5_release", {s_ack, s_busy}, {3'b000, 1'b1});
      if (k == 7) chk("s5_gap", {s_gnt, s_busy}, {3'b000, 1'b1});
    end
    chk("s5_acks", acks, 5);
    chk("s5_idle", s_busy, 1'b0);

    // Length 15 held: clamped to 8 beats
    req = 3'b001; a[0] = 16'h0900; acks = 0;
    push_beats(2'd0, 16'h0900, 8, 1'b1);
    for (int k = 0; k < 11; k++) begin
      step();
      acks += int'(s_ack != 3'b000);
      if (k == 8) req = 3'b000;
      if (k == 9) chk("clamp_gap", {s_gnt, s_busy}, {3'b000, 1'b1});
    end
    chk("clamp_acks", acks, 8);

    // Length 0 counts as one beat
    req = 3'b010; len[1] = 4'd0; we = 3'b010; a[1] = 16'h0A00; acks = 0;
    push_beats(2'd1, 16'h0A00, 1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step();
      acks += int'(s_ack != 3'b000);
      if (k == 2) req = 3'b000;
    end
    chk("len0_acks", acks, 1);

    // Reset during the 2nd beat of a 4-beat read burst
    req = 3'b001; len[0] = 4'd4; we = 3'b000; a[0] = 16'h0700;
    push_beats(2'd0, 16'h0700, 2, 1'b0);
    step(); step();
    n_rst = 1'b0;
    step();
    rd_q.delete();
    n_rst = 1'b1; req = 3'b000;
    step();
    chk("rst_mid_ctl", s_ctl, 28'd0);
    chk("rst_mid_dat", s_dat, 64'd0);
`ifdef FB_ARB_STATS_EN
    chk("stats_after_reset", grant_cnt, 48'd0);
`endif
    // rr_ptr must be back at 0: requester 0 wins over 1
    req = 3'b011; len[0] = 4'd1; len[1] = 4'd1; we = 3'b011; a[0] = 16'h0B00;
    push_beats(2'd0, 16'h0B00, 1, 1'b1);
    step(); step(); chk("rst_rr_gnt", s_gnt, 3'b001);
    req = 3'b000; step(); step();

`ifdef FB_ARB_STATS_EN
    for (int n = 0; n < 2; n++) begin
      req = 3'b001; a[0] = 16'h0C00;
      push_beats(2'd0, 16'h0C00, 1, 1'b1);
      step(); step(); req = 3'b000; step(); step();
    end
    chk("stats_three", grant_cnt, {16'd0, 16'd0, 16'd3});
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    chk("stats_clr", grant_cnt, 48'd0);
`endif

    chk("final_beat_q", beat_q.size(), 0);
    chk("final_rd_q", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
